risc_mem_resp: RTL and testbench

Word-addressed data/instruction memory responder serving the pipelined core's memory port. Accepts one load or store request at a time over a valid/ready handshake. Applies a programmable number of wait states, performs the access, and returns a response (read data or write acknowledge) over a second valid/ready handshake. Sits between the core's MEM-stage load/store logic and the storage array, replacing the core-internal memory array.

---
 rtl/risc_mem_resp_pkg.sv | 23 ++
 rtl/risc_mem_resp_if.sv | 27 ++
 rtl/risc_mem_resp_array.sv | 33 +++
 rtl/risc_mem_resp.sv | 136 +++++++++++++
 tb/tb_risc_mem_resp.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_mem_resp_pkg.sv
// risc_mem_pkg: shared constants, FSM state type and helpers for the
// memory responder slice.
package risc_mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WAIT_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      RESP = ST_RESP
   } state_e;

   // True when a word address lies beyond a 2**aw-word array.
   function automatic logic addr_oob(input logic [WORD_W-1:0] addr, input int unsigned aw);
      return (addr >> aw) != '0;
   endfunction

endpackage

// File: rtl/risc_mem_resp_if.sv
// risc_mem_resp_if: request/response handshake bundle between the core's
// MEM stage (master) and the memory responder (slave).
interface risc_mem_resp_if;
   import risc_mem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              flush;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, flush, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, flush, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/risc_mem_resp_array.sv
// mem_resp_array: DEPTH x 32 storage, one synchronous read/write port.
// No reset; read data holds its last value while the port is idle.
module mem_resp_array
   import risc_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   // Single port: a store writes the array, a load captures the word.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/risc_mem_resp.sv
// risc_mem_resp: word-addressed memory responder with programmable wait
// states. Optional bounds checking is enabled by MEM_RESP_BOUNDS_CHECK_EN.
module risc_mem_resp
   import risc_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic            clk1,
   input  logic            rst_n,
   risc_mem_resp_if.slave  bus
);

   localparam int unsigned       AW        = $clog2(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              zero_q, zero_d;
   logic              err_q, err_d;

   logic              accept;
   logic              access;
   logic              acc_we;
   logic [WORD_W-1:0] acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic              acc_err;
   logic [WORD_W-1:0] arr_rdata;

   assign accept = (state_q == IDLE) && bus.req_valid;

   // With zero wait states the access happens on the accept edge, so the
   // array is fed straight from the bus; otherwise from the request latch.
   assign acc_we    = (state_q == IDLE) ? bus.req_we    : we_q;
   assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

`ifdef MEM_RESP_BOUNDS_CHECK_EN
   assign acc_err = addr_oob(acc_addr, AW);
`else
   logic unused_addr_hi;
   assign acc_err        = 1'b0;
   assign unused_addr_hi = ^acc_addr[WORD_W-1:AW];
`endif

   // FSM and wait counter; access strobes on the edge entering RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               cnt_d = WAIT_INIT;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  access  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_W'(1)) begin
               state_d = RESP;
               access  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch and response qualifiers.
   always_comb begin
      we_d    = accept ? bus.req_we    : we_q;
      addr_d  = accept ? bus.req_addr  : addr_q;
      wdata_d = accept ? bus.req_wdata : wdata_q;
      zero_d  = access ? (acc_we || acc_err) : zero_q;
      err_d   = access ? acc_err : err_q;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         zero_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   mem_resp_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk_i   (clk1),
      .en_i    (access && !(acc_we && acc_err)),
      .we_i    (acc_we),
      .addr_i  (acc_addr[AW-1:0]),
      .wdata_i (acc_wdata),
      .rdata_o (arr_rdata)
   );

   // Read data is taken from the array's output register and masked to zero
   // for store acknowledges, errors and the post-reset state.
   assign bus.rsp_rdata = zero_q ? '0 : arr_rdata;
   assign bus.rsp_err   = err_q;
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_risc_mem_resp.sv
// tb_risc_mem_resp: three responders (WAIT_CYCLES 1, 3, 0) driven by
// scenario tasks and checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_risc_mem_resp;
   import risc_mem_pkg::*;

   localparam int unsigned DEPTH = 1024;
   localparam int          NDUT  = 3;

   function automatic int wc_of(input int d);
      case (d)
         0:       return 1;
         1:       return 3;
         default: return 0;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst_n;

   logic [NDUT-1:0] req_valid, req_we, flush, rsp_ready;
   logic [NDUT-1:0] req_ready, rsp_valid, rsp_err;
   logic [31:0]     req_addr  [NDUT];
   logic [31:0]     req_wdata [NDUT];
   logic [31:0]     rsp_rdata [NDUT];

   logic [31:0] ref_mem [NDUT][DEPTH];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      risc_mem_resp_if bus ();
      assign bus.req_valid = req_valid[g];
      assign bus.req_we    = req_we[g];
      assign bus.req_addr  = req_addr[g];
      assign bus.req_wdata = req_wdata[g];
      assign bus.flush     = flush[g];
      assign bus.rsp_ready = rsp_ready[g];
      assign req_ready[g]  = bus.req_ready;
      assign rsp_valid[g]  = bus.rsp_valid;
      assign rsp_rdata[g]  = bus.rsp_rdata;
      assign rsp_err[g]    = bus.rsp_err;

      risc_mem_resp #(
         .DEPTH       (DEPTH),
         .WAIT_CYCLES (wc_of(g))
      ) u_dut (
         .clk1  (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );
   end

   // Transaction-level reference: returns what the response must carry.
   task automatic model(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] exp_rd, output logic exp_er);
      logic oob;
      oob = (addr >= DEPTH);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      exp_er = oob;
`else
      exp_er = 1'b0;
`endif
      exp_rd = '0;
      if (!exp_er) begin
         if (we) ref_mem[d][addr % DEPTH] = wd;
         else    exp_rd = ref_mem[d][addr % DEPTH];
      end
   endtask

   // Presents a request at a negedge and returns at the negedge where the
   // response is first seen (or the budget expires); lat counts cycles.
   task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd;
      while (req_ready[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat = 1;
      while (rsp_valid[d] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      rd = rsp_rdata[d];
      er = rsp_err[d];
   endtask

   task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output logic [31:0] exp_rd, output logic exp_er);
      issue(d, we, addr, wd, lat, rd, er);
      model(d, we, addr, wd, exp_rd, exp_er);
      if (rsp_valid[d] === 1'b1) begin
         rsp_ready[d] = 1'b1;
         @(negedge clk);
         rsp_ready[d] = 1'b0;
      end
   endtask

   task automatic test_reset();
      int lat; logic [31:0] rd, erd; logic er, eer; bit seen;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         total++;
         if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_state dut%0d: valid=%b ready=%b rdata=%h err=%b, want 0 1 0 0",
                     d, rsp_valid[d], req_ready[d], rsp_rdata[d], rsp_err[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      xact(1, 1'b1, 32'd5, 32'h1111_0005, lat, rd, er, erd, eer);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'd5; req_wdata[1] = 32'hBAD0_0005;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      total++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
         bad++;
         $display("FAIL mid_wait dut1: valid=%b ready=%b, want 0 0", rsp_valid[1], req_ready[1]);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_wait: valid=%b ready=%b, want 0 1", rsp_valid[1], req_ready[1]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (rsp_valid[1] !== 1'b0) seen = 1'b1; end
      total++;
      if (seen) begin bad++; $display("FAIL reset_no_resp: response seen=%b, want 0", seen); end
      xact(1, 1'b0, 32'd5, 32'h0, lat, rd, er, erd, eer);
      total++;
      if (rd !== erd) begin bad++; $display("FAIL reset_store_dropped: rdata=%h want %h", rd, erd); end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd, erd; logic er, eer;
      logic [31:0] pool [8];
      xact(0, 1'b1, 32'd12, 32'hDEAD_BEEF, lat, rd, er, erd, eer);
      total++;
      if (rd !== 32'h0 || lat != 2) begin bad++; $display("FAIL store_ack: rdata=%h lat=%0d want 0 2", rd, lat); end
      xact(0, 1'b0, 32'd12, 32'h0, lat, rd, er, erd, eer);
      total++;
      if (rd !== 32'hDEAD_BEEF || lat != 2) begin bad++; $display("FAIL load_12: rdata=%h lat=%0d want deadbeef 2", rd, lat); end
      for (int i = 0; i < 8; i++) begin
         pool[i] = $urandom_range(DEPTH - 1);
         xact(0, 1'b1, pool[i], $urandom, lat, rd, er, erd, eer);
      end
      for (int i = 0; i < 24; i++) begin
         logic we;
         we = 1'($urandom_range(1));
         xact(0, we, pool[$urandom_range(7)], $urandom, lat, rd, er, erd, eer);
         total++;
         if (rd !== erd || er !== eer || lat != wc_of(0) + 1) begin
            bad++;
            $display("FAIL rand_op%0d we=%b: rdata=%h err=%b lat=%0d want %h %b %0d", i, we, rd, er, lat, erd, eer, wc_of(0) + 1);
         end
      end
   endtask

   task automatic test_stall();
      int lat; logic [31:0] rd, erd; logic er, eer;
      issue(1, 1'b0, 32'd5, 32'h0, lat, rd, er);
      model(1, 1'b0, 32'd5, 32'h0, erd, eer);
      total++;
      if (lat != 4 || rd !== erd) begin bad++; $display("FAIL stall_first: lat=%0d rdata=%h want 4 %h", lat, rd, erd); end
      for (int c = 0; c < 4; c++) begin
         flush[1] = 1'b1;
         @(negedge clk);
         total++;
         if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== erd || req_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold%0d: valid=%b rdata=%h ready=%b want 1 %h 0", c, rsp_valid[1], rsp_rdata[1], req_ready[1], erd);
         end
      end
      flush[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      rsp_ready[1] = 1'b0;
      total++;
      if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: ready=%b valid=%b want 1 0", req_ready[1], rsp_valid[1]);
      end
   endtask

   task automatic test_flush();
      int lat; logic [31:0] rd, erd; logic er, eer; bit seen;
      for (int d = 0; d < 2; d++) begin
         xact(d, 1'b1, 32'd7, 32'hA5A5_0007 + d, lat, rd, er, erd, eer);
         req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'd7; req_wdata[d] = 32'h0000_1234;
         for (int k = 1; k <= wc_of(d); k++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            if (k == wc_of(d)) flush[d] = 1'b1;
         end
         @(negedge clk);
         flush[d] = 1'b0;
         seen = 1'b0;
         total++;
         if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL flush_idle dut%0d: ready=%b want 1", d, req_ready[d]); end
         repeat (6) begin if (rsp_valid[d] !== 1'b0) seen = 1'b1; @(negedge clk); end
         total++;
         if (seen) begin bad++; $display("FAIL flush_no_resp dut%0d: response seen=%b want 0", d, seen); end
         xact(d, 1'b0, 32'd7, 32'h0, lat, rd, er, erd, eer);
         total++;
         if (rd !== erd) begin bad++; $display("FAIL flush_old_value dut%0d: rdata=%h want %h", d, rd, erd); end
      end
   endtask

   task automatic test_bounds();
      int lat; logic [31:0] rd, erd; logic er, eer;
      logic [31:0] addrs [5];
      logic        wes   [5];
      logic [31:0] wds   [5];
      addrs = '{32'd0, 32'd1024, 32'd1024, 32'd0, 32'd1023};
      wes   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      wds   = '{32'h600D_0000, 32'h0, 32'h5555_AAAA, 32'h0, 32'h0FF0_03FF};
      for (int i = 0; i < 5; i++) begin
         xact(0, wes[i], addrs[i], wds[i], lat, rd, er, erd, eer);
         total++;
         if (rd !== erd || er !== eer) begin
            bad++;
            $display("FAIL bounds%0d addr=%0d we=%b: rdata=%h err=%b want %h %b", i, addrs[i], wes[i], rd, er, erd, eer);
         end
      end
      xact(0, 1'b0, 32'd1023, 32'h0, lat, rd, er, erd, eer);
      total++;
      if (rd !== erd || er !== eer) begin bad++; $display("FAIL bounds_top: rdata=%h err=%b want %h %b", rd, er, erd, eer); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd, erd; logic er, eer;
      logic [31:0] pool [4];
      for (int i = 0; i < 4; i++) begin
         pool[i] = $urandom_range(DEPTH - 1);
         xact(2, 1'b1, pool[i], $urandom, lat, rd, er, erd, eer);
         total++;
         if (lat != 1 || rd !== 32'h0) begin bad++; $display("FAIL b2b_seed%0d: lat=%0d rdata=%h want 1 0", i, lat, rd); end
      end
      rsp_ready[2] = 1'b1;
      req_we[2]    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         req_addr[2]  = pool[$urandom_range(3)];
         req_valid[2] = 1'b1;
         model(2, 1'b0, req_addr[2], 32'h0, erd, eer);
         total++;
         if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept%0d: ready=%b valid=%b want 1 0", k, req_ready[2], rsp_valid[2]);
         end
         @(negedge clk);
         total++;
         if (rsp_valid[2] !== 1'b1 || rsp_rdata[2] !== erd || req_ready[2] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_resp%0d: valid=%b rdata=%h ready=%b want 1 %h 0", k, rsp_valid[2], rsp_rdata[2], req_ready[2], erd);
         end
         @(negedge clk);
      end
      req_valid[2] = 1'b0;
      rsp_ready[2] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; flush = '0; rsp_ready = '0;
      for (int d = 0; d < NDUT; d++) begin req_addr[d] = '0; req_wdata[d] = '0; end
      test_reset();
      test_store_load();
      test_stall();
      test_flush();
      test_bounds();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
